// File: rtl/bp_pht_scheduler.sv
// Single-port PHT owner: arbitrates fetch lookups against FIFO-buffered 2-bit counter
// training (read-modify-write). Defining BP_PHT_STATS_EN adds lookup/update/stall counters.
module bp_pht_scheduler #(
  parameter int IDX_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic [1:0]       pred_ctr,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [1:0]       mem_wdata,
  input  logic [1:0]       mem_rdata,
  output logic             init_done
`ifdef BP_PHT_STATS_EN
  ,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_updates,
  output logic [31:0]      stat_stalls
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_WR} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   init_addr_q, init_addr_d;
  logic               init_done_q, init_done_d;
  logic               pred_valid_q, pred_valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ST_W-1:0]    starve_q, starve_d;
  logic [IDX_W-1:0]   fifo_idx_q [FIFO_DEPTH];
  logic               fifo_tkn_q [FIFO_DEPTH];

  logic             fifo_full, fifo_empty, force_upd, grant, push, pop, head_tkn;
  logic [IDX_W-1:0] head_idx;
  logic [1:0]       new_ctr;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign force_upd  = fifo_full || ((starve_q == ST_W'(STARVE_MAX)) && !fifo_empty);
  assign lookup_ready = !rst && (state_q == S_IDLE) && !force_upd;
  assign upd_ready    = !rst && init_done_q && !fifo_full;
  assign grant = lookup_valid && lookup_ready;
  assign push  = upd_valid && upd_ready;
  assign pop   = !rst && (state_q == S_UPD_WR);
  assign head_idx = fifo_idx_q[rd_ptr_q];
  assign head_tkn = fifo_tkn_q[rd_ptr_q];

  always_comb begin
    if (head_tkn) new_ctr = (mem_rdata == 2'd3) ? 2'd3 : mem_rdata + 2'd1;
    else          new_ctr = (mem_rdata == 2'd0) ? 2'd0 : mem_rdata - 2'd1;
  end

  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    init_done_d  = init_done_q;
    pred_valid_d = grant;
    starve_d     = starve_q;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = 2'b00;
    // Outputs stay quiet while rst is high; the flops themselves reset on the edge.
    if (!rst) begin
      case (state_q)
        S_INIT: begin
          mem_en      = 1'b1;
          mem_we      = 1'b1;
          mem_addr    = init_addr_q;
          mem_wdata   = 2'b01;
          init_addr_d = init_addr_q + IDX_W'(1);
          if (init_addr_q == '1) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end
        end
        S_IDLE: begin
          if (grant) begin
            mem_en   = 1'b1;
            mem_addr = lookup_idx;
            if (!fifo_empty && (starve_q != ST_W'(STARVE_MAX))) starve_d = starve_q + ST_W'(1);
          end else if (!fifo_empty) begin
            mem_en   = 1'b1;
            mem_addr = head_idx;
            state_d  = S_UPD_WR;
          end
        end
        S_UPD_WR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = head_idx;
          mem_wdata = new_ctr;
          starve_d  = '0;
          state_d   = S_IDLE;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      init_addr_q  <= '0;
      init_done_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      init_done_q  <= init_done_d;
      pred_valid_q <= pred_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      if (push) begin
        fifo_idx_q[wr_ptr_q] <= upd_idx;
        fifo_tkn_q[wr_ptr_q] <= upd_taken;
      end
    end
  end

  assign init_done  = init_done_q && !rst;
  assign pred_valid = pred_valid_q && !rst;
  assign pred_ctr   = pred_valid ? mem_rdata : 2'b00;
  assign pred_taken = pred_ctr[1];

`ifdef BP_PHT_STATS_EN
  logic [31:0] stat_lookups_q, stat_updates_q, stat_stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_updates_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      if (grant) stat_lookups_q <= stat_lookups_q + 32'd1;
      if (pop)   stat_updates_q <= stat_updates_q + 32'd1;
      if (lookup_valid && !lookup_ready && init_done_q) stat_stalls_q <= stat_stalls_q + 32'd1;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_updates = stat_updates_q;
  assign stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: doc/bp_pht_scheduler.md
# bp_pht_scheduler

Scheduler and owner of the single-port pattern history table (PHT) inside `branch_prediction`. It shares the one SRAM port between fetch-stage prediction lookups and resolve-stage training updates. Updates are buffered in a small FIFO and applied as read-modify-write of 2-bit saturating counters. After reset it runs an init sweep that writes every entry before any traffic is accepted.

## Interface
- `IDX_W`, 8: PHT index width; table has 2^IDX_W entries.
- `FIFO_DEPTH`, 4: update FIFO entries; power of two, at least 2.
- `STARVE_MAX`, 7: consecutive lookup grants, with FIFO non-empty, after which one update is forced.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `lookup_valid` in 1: fetch requests a prediction.
- `lookup_idx` in IDX_W: PHT index for the lookup.
- `lookup_ready` out 1: lookup accepted this cycle when high together with `lookup_valid`.
- `pred_valid` out 1: prediction result valid.
- `pred_ctr` out 2: counter value read for the accepted lookup.
- `pred_taken` out 1: `pred_ctr[1]`.
- `upd_valid` in 1: resolved branch to train.
- `upd_idx` in IDX_W: index to train.
- `upd_taken` in 1: actual outcome.
- `upd_ready` out 1: FIFO can accept an update.
- `mem_en` out 1: SRAM access enable.
- `mem_we` out 1: write enable.
- `mem_addr` out IDX_W: SRAM address.
- `mem_wdata` out 2: SRAM write data.
- `mem_rdata` in 2: SRAM read data, valid the cycle after a read.
- `init_done` out 1: init sweep complete.

## Operation
- States: INIT, IDLE, UPD_WR.
- INIT
  - Writes 2'b01 (weakly not-taken) to addresses 0 … 2^IDX_W−1, one per cycle.
  - `lookup_ready` and `upd_ready` are 0.
  - After the write to the last address, moves to IDLE and sets `init_done`=1.
- `upd_ready` = `init_done` && FIFO not full. An update is pushed when `upd_valid` && `upd_ready`.
- `force` = FIFO full || (`starve_cnt` == STARVE_MAX && FIFO non-empty).
- `lookup_ready` = (state == IDLE) && !`force`.
- IDLE, lookup granted:
  - Drives `mem_en`=1, `mem_we`=0, `mem_addr`=`lookup_idx`.
  - Stays in IDLE.
  - If the FIFO is non-empty, `starve_cnt` increments, saturating at STARVE_MAX.
- IDLE, no lookup granted and FIFO non-empty:
  - Drives a read of the FIFO head index.
  - Moves to UPD_WR.
- IDLE, nothing to do: `mem_en`=0.
- UPD_WR:
  - Writes the new counter to the head index.
  - Taken: new = min(`mem_rdata`+1, 3). Not taken: new = max(`mem_rdata`−1, 0).
  - Pops the FIFO, clears `starve_cnt`, returns to IDLE.
  - `lookup_ready`=0.
- Simultaneous FIFO push and pop in the same cycle is legal; the count is unchanged.
- Updates are applied in arrival order. A lookup never observes a partially written counter.

## Timing
- Lookup latency: `pred_valid` and `pred_ctr` are asserted 1 cycle after the grant and held for that cycle only.
- Back-to-back lookups sustain 1 per cycle.
- An update occupies the port for 2 cycles (read, then write). The lookup stall is 1 cycle, during UPD_WR.
- An update pushed at cycle t:
  - Earliest read at t+1, write at t+2.
  - A lookup of the same index granted at t+3 or later sees the new value.
- Init takes 2^IDX_W cycles after `rst` deasserts; `init_done` rises on the following edge.
- Reset values: state INIT, init address 0, FIFO empty, `starve_cnt` 0.
- Output values during reset: `init_done`=0, `pred_valid`=0, `pred_ctr`=0, `lookup_ready`=0, `upd_ready`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation (INIT or UPD_WR):
  - Pending updates are discarded and an in-flight write is abandoned.
  - The init sweep restarts from address 0.

## Configuration
- `BP_PHT_STATS_EN` defined: adds three 32-bit outputs, all cleared by `rst` and wrapping on overflow.
  - `stat_lookups`: counts granted lookups.
  - `stat_updates`: counts completed UPD_WR cycles.
  - `stat_stalls`: counts cycles with `lookup_valid` && !`lookup_ready` after `init_done`.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Init, IDX_W=4:
  - Release `rst`: exactly 16 writes of 2'b01 to addresses 0–15.
  - `init_done` rises 16 cycles after release.
  - A lookup of index 5 then returns `pred_ctr`=1, `pred_taken`=0.
- Saturation:
  - Three taken updates to index 3, then a lookup: `pred_ctr`=3.
  - A fourth taken update: still 3.
  - Four not-taken updates: 0.
- Starvation, STARVE_MAX=7:
  - Continuous `lookup_valid` with one queued update.
  - Exactly 7 grants, then `lookup_ready`=0 for 2 cycles while the update is read and written, then grants resume.
- FIFO full, FIFO_DEPTH=4:
  - Push 4 updates during continuous lookups: `upd_ready`=0 on the next cycle and `lookup_ready` drops immediately.
  - One pop re-raises `upd_ready`.
- Push/pop same cycle: with FIFO at 2 entries, push during UPD_WR leaves the count at 2. Entries are applied in order.
- Mid-operation reset:
  - Assert `rst` during UPD_WR with 3 queued updates.
  - FIFO empties, the sweep restarts at address 0, and no queued update is ever written.
